fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 24-bit CPU. Holds the program counter and fetches one 24-bit instruction word per request from instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Takes the redirect target from the branch-select 2:1 mux sitting directly upstream, and feeds PCPlus1 back to that mux's sequential input.

Parameters:
- DATA_WIDTH, 24, instruction word width.
- ADDR_WIDTH, 24, PC / instruction memory address width (word addressed).
- RESET_PC, 24'h000000, PC value after reset.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately.
- Halt  input  1  1 = do not start new fetches (HLT executed).
- Redirect  input  1  1 = branch/jump taken this cycle.
- RedirectPC  input  ADDR_WIDTH  target PC from the branch-select mux, sampled when Redirect=1.
- MemReq  output  1  fetch request to instruction memory.
- MemAddr  output  ADDR_WIDTH  fetch address; equals the PC register.
- MemAck  input  1  memory response strobe; MemData valid in the same cycle.
- MemData  input  DATA_WIDTH  instruction word from memory.
- InstrValid  output  1  InstrOut/InstrPC hold a valid instruction.
- InstrReady  input  1  decode accepts the instruction this cycle.
- InstrOut  output  DATA_WIDTH  latched instruction.
- InstrPC  output  ADDR_WIDTH  address of InstrOut.
- PCPlus1  output  ADDR_WIDTH  InstrPC+1 (combinational, mod 2^24); sequential input of the branch-select mux.

Behaviour:
Reset values:
- state=IDLE, PC=RESET_PC, MemReq=0, InstrValid=0, InstrOut=0, InstrPC=0.
- Reset asserted mid-fetch abandons the request immediately. Memory must tolerate a dropped MemReq.

States and transitions (all registered):
- IDLE: MemReq=0, InstrValid=0.
  - Redirect=1: PC<=RedirectPC; stay IDLE if Halt=1, else go to REQ.
  - Halt=0: go to REQ.
- REQ: MemReq=1, MemAddr=PC, held stable until MemAck. MemAck may arrive in the first REQ cycle.
  - Redirect=1 without MemAck: PC<=RedirectPC, go to DROP.
  - Redirect=1 with MemAck in the same cycle: discard MemData, PC<=RedirectPC, go to REQ (IDLE if Halt=1).
  - MemAck=1, Redirect=0: InstrOut<=MemData, InstrPC<=PC, PC<=PC+1, go to HOLD.
- DROP: MemReq=1, MemAddr holds the old (pre-redirect) address. A shadow register keeps it; PC already holds the new target.
  - MemAck: discard data, go to REQ (IDLE if Halt=1).
  - Further Redirect: overwrite PC only; stay in DROP.
- HOLD: InstrValid=1, MemReq=0. InstrOut/InstrPC stay stable until accepted.
  - Redirect=1 (priority over InstrReady): InstrValid<=0, PC<=RedirectPC, go to REQ (IDLE if Halt=1).
  - InstrReady=1: go to REQ if Halt=0, else IDLE.
  - Otherwise stay.

Timing and arithmetic:
- Latency: MemAck in cycle t gives InstrValid=1 in cycle t+1.
- Best-case throughput is 1 instruction per 2 cycles (single-cycle memory, InstrReady held 1).
- PC wraps 24'hFFFFFF -> 24'h000000, and PCPlus1 wraps the same way. No overflow flag.

Halt:
- Never aborts an outstanding request or a HOLD instruction.
- Only blocks the next REQ.
- Deasserting Halt in IDLE starts REQ on the next cycle.

Test Plan:
1. Release Reset, Halt=0, memory acks in first REQ cycle with data = address XOR 24'hA5A5A5, InstrReady=1 -> InstrPC sequence 0,1,2,3 with InstrOut A5A5A5,A5A5A4,A5A5A7,A5A5A6; InstrValid pulses every 2nd cycle; PCPlus1 = InstrPC+1.
2. Memory acks 3 cycles after MemReq, InstrReady=0 for 4 cycles in HOLD -> MemAddr stable through wait; InstrOut/InstrPC unchanged while InstrValid=1; next fetch starts only after InstrReady=1.
3. Redirect=1, RedirectPC=24'h000100 during REQ at addr 5 before ack -> DROP keeps MemAddr=5 until ack; that data is never shown as valid; next MemAddr=24'h000100.
4. Redirect with RedirectPC=24'h000200 while in HOLD with InstrPC=7, InstrReady=1 same cycle -> instruction 7 is not accepted; InstrValid=0 next cycle; next fetch address 24'h000200.
5. RESET_PC=24'hFFFFFF -> first InstrPC=24'hFFFFFF with PCPlus1=24'h000000; second fetch address 24'h000000.
6. Halt=1 during REQ at addr 9 -> fetch 9 completes and is delivered, then IDLE with MemReq=0. Halt=0 -> MemAddr=10 next cycle. Reset pulse low mid-REQ -> MemReq=0 and MemAddr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC holder and instruction fetch stage (mem req/ack in,
//               valid/ready out to decode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_out_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus1_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic [ADDR_WIDTH-1:0] shadow_q,   shadow_d;
    logic [DATA_WIDTH-1:0] instr_q,    instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [1:0]            resume_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            shadow_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            shadow_q   <= shadow_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Halt only gates the start of the next request, never an ongoing one.
    assign resume_state = halt_i ? S_IDLE : S_REQ;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        shadow_d   = shadow_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                state_d = resume_state;
            end
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    if (mem_ack_i) begin
                        state_d = resume_state;
                    end else begin
                        // Bus address must stay stable until the old request is acked.
                        shadow_d = pc_q;
                        state_d  = S_DROP;
                    end
                end else if (mem_ack_i) begin
                    instr_d    = mem_data_i;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + ADDR_WIDTH'(1);
                    state_d    = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    state_d = resume_state;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = resume_state;
                end else if (instr_ready_i) begin
                    state_d = resume_state;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = (state_q == S_REQ) || (state_q == S_DROP);
        instr_valid_o = (state_q == S_HOLD);
        mem_addr_o    = (state_q == S_DROP) ? shadow_q : pc_q;
    end

    assign instr_out_o = instr_q;
    assign instr_pc_o  = instr_pc_q;
    assign pc_plus1_o  = instr_pc_q + ADDR_WIDTH'(1);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed plus randomized bench for fetch_unit with a
//               transaction-level reference model and memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [23:0] C_XOR = 24'hA5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [23:0] rpc = '0;
    logic        ack = 1'b0;
    logic [23:0] data = '0;
    logic        ready = 1'b1;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic        instr_valid_o;
    logic [23:0] instr_out_o;
    logic [23:0] instr_pc_o;
    logic [23:0] pc_plus1_o;

    // Second instance with a wrapping reset PC, free-running against a zero-wait memory.
    logic        halt_b = 1'b0;
    logic        redirect_b = 1'b0;
    logic [23:0] rpc_b = '0;
    logic        ready_b = 1'b1;
    logic        req_b;
    logic [23:0] addr_b;
    logic        valid_b;
    logic [23:0] out_b;
    logic [23:0] ipc_b;
    logic [23:0] plus1_b;
    logic        ack_b;
    logic [23:0] data_b;
    assign ack_b  = req_b;
    assign data_b = addr_b ^ C_XOR;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [23:0] m_pc, m_drop_addr, m_instr, m_ipc;
    bit          m_busy, m_drop, m_hold;
    int          mem_delay = 0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(24), .ADDR_WIDTH(24), .RESET_PC(24'h000000)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .redirect_i(redirect),
        .redirect_pc_i(rpc), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(ack), .mem_data_i(data), .instr_valid_o(instr_valid_o),
        .instr_ready_i(ready), .instr_out_o(instr_out_o), .instr_pc_o(instr_pc_o),
        .pc_plus1_o(pc_plus1_o)
    );

    fetch_unit #(.DATA_WIDTH(24), .ADDR_WIDTH(24), .RESET_PC(24'hFFFFFF)) u_dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt_b), .redirect_i(redirect_b),
        .redirect_pc_i(rpc_b), .mem_req_o(req_b), .mem_addr_o(addr_b),
        .mem_ack_i(ack_b), .mem_data_i(data_b), .instr_valid_o(valid_b),
        .instr_ready_i(ready_b), .instr_out_o(out_b), .instr_pc_o(ipc_b),
        .pc_plus1_o(plus1_b)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_addr();
        return m_drop ? m_drop_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_pc = 24'h000000; m_drop_addr = '0; m_instr = '0; m_ipc = '0;
        m_busy = 0; m_drop = 0; m_hold = 0;
        wait_cnt = 0;
    endtask

    task automatic model_step();
        if (m_hold) begin
            if (redirect) begin
                m_pc = rpc; m_hold = 0; m_busy = !halt;
            end else if (ready) begin
                m_hold = 0; m_busy = !halt;
            end
        end else if (m_busy) begin
            if (m_drop) begin
                if (redirect) m_pc = rpc;
                if (ack) begin m_drop = 0; m_busy = !halt; end
            end else if (redirect) begin
                if (ack) m_busy = !halt;
                else begin m_drop = 1; m_drop_addr = m_pc; end
                m_pc = rpc;
            end else if (ack) begin
                m_instr = data; m_ipc = m_pc; m_pc = m_pc + 24'd1;
                m_hold = 1; m_busy = 0;
            end
        end else begin
            if (redirect) m_pc = rpc;
            m_busy = !halt;
        end
    endtask

    // One clock: compare outputs mid-cycle, drive memory response, advance model.
    task automatic cycle();
        @(negedge clk);
        chk("mem_req",   {23'd0, mem_req_o},     {23'd0, m_busy});
        chk("mem_addr",  mem_addr_o,             exp_addr());
        chk("valid",     {23'd0, instr_valid_o}, {23'd0, m_hold});
        chk("instr_out", instr_out_o,            m_instr);
        chk("instr_pc",  instr_pc_o,             m_ipc);
        chk("pc_plus1",  pc_plus1_o,             m_ipc + 24'd1);
        ack  = m_busy && (wait_cnt >= mem_delay);
        data = exp_addr() ^ C_XOR;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_busy && !ack) wait_cnt++;
            else wait_cnt = 0;
            model_step();
        end
        #1;
    endtask

    initial begin
        bit found;
        int nval;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",   {23'd0, mem_req_o},     24'd0);
        chk("rst_valid", {23'd0, instr_valid_o}, 24'd0);
        chk("rst_addr",  mem_addr_o,             24'h000000);
        chk("rst_instr", instr_out_o,            24'd0);
        chk("rst_ipc",   instr_pc_o,             24'd0);
        chk("rstb_addr", addr_b,                 24'hFFFFFF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-cycle memory, decode always ready.
        nval = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t1_valid_pattern", {23'd0, instr_valid_o}, {23'd0, k[0]});
            if (instr_valid_o) begin
                chk("t1_ipc",   instr_pc_o,  24'(nval));
                chk("t1_instr", instr_out_o, 24'(nval) ^ C_XOR);
                chk("t1_plus1", pc_plus1_o,  24'(nval + 1));
                nval++;
            end
            if (k == 0) begin
                chk("t5_req",  {23'd0, req_b}, 24'd1);
                chk("t5_addr", addr_b, 24'hFFFFFF);
            end
            if (k == 1) begin
                chk("t5_valid", {23'd0, valid_b}, 24'd1);
                chk("t5_ipc",   ipc_b,   24'hFFFFFF);
                chk("t5_plus1", plus1_b, 24'h000000);
                chk("t5_instr", out_b,   24'h5A5A5A);
            end
            if (k == 2) chk("t5_addr2", addr_b, 24'h000000);
        end
        chk("t1_count", 24'(nval), 24'd4);

        // Slow memory, decode stalls.
        mem_delay = 3;
        cycle();
        ready = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        chk("t2_held_valid", {23'd0, instr_valid_o}, 24'd1);
        chk("t2_held_ipc",   instr_pc_o, 24'd4);
        chk("t2_no_req",     {23'd0, mem_req_o}, 24'd0);
        ready = 1'b1;
        cycle();
        chk("t2_next_addr", mem_addr_o, 24'd5);

        // Redirect during an outstanding request.
        redirect = 1'b1; rpc = 24'h000100;
        cycle();
        redirect = 1'b0;
        chk("t3_drop_addr", mem_addr_o, 24'd5);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle();
            chk("t3_not_shown", {23'd0, instr_valid_o && instr_pc_o == 24'd5}, 24'd0);
            if (mem_req_o && mem_addr_o == 24'h000100) found = 1;
        end
        chk("t3_new_addr", {23'd0, found}, 24'd1);

        // Redirect wins over ready in HOLD.
        mem_delay = 0; ready = 1'b0;
        redirect = 1'b1; rpc = 24'd7;
        cycle();
        redirect = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (instr_valid_o && instr_pc_o == 24'd7) found = 1;
        end
        chk("t4_hold7", {23'd0, found}, 24'd1);
        redirect = 1'b1; rpc = 24'h000200; ready = 1'b1;
        cycle();
        redirect = 1'b0;
        chk("t4_valid_drop", {23'd0, instr_valid_o}, 24'd0);
        chk("t4_addr", mem_addr_o, 24'h000200);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (instr_valid_o) begin
                found = 1;
                chk("t4_next_ipc", instr_pc_o, 24'h000200);
            end
        end
        chk("t4_delivered", {23'd0, found}, 24'd1);

        // Halt behaviour.
        halt = 1'b1; mem_delay = 2;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (!mem_req_o && !instr_valid_o) found = 1;
        end
        chk("t6_idle", {23'd0, found}, 24'd1);
        redirect = 1'b1; rpc = 24'd9; halt = 1'b0;
        cycle();
        redirect = 1'b0;
        chk("t6_req9", {23'd0, mem_req_o}, 24'd1);
        chk("t6_addr9", mem_addr_o, 24'd9);
        halt = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (instr_valid_o) found = 1;
        end
        chk("t6_delivered", {23'd0, found}, 24'd1);
        chk("t6_ipc9", instr_pc_o, 24'd9);
        cycle();
        chk("t6_idle_req", {23'd0, mem_req_o}, 24'd0);
        chk("t6_idle_addr", mem_addr_o, 24'd10);
        cycle();
        chk("t6_still_idle", {23'd0, mem_req_o}, 24'd0);
        halt = 1'b0;
        cycle();
        chk("t6_resume_req", {23'd0, mem_req_o}, 24'd1);
        chk("t6_resume_addr", mem_addr_o, 24'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_req",  {23'd0, mem_req_o}, 24'd0);
        chk("t6_async_addr", mem_addr_o, 24'h000000);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("t6_after_rst", mem_addr_o, 24'h000000);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            halt      = ($urandom_range(0, 99) < 12);
            redirect  = ($urandom_range(0, 99) < 15);
            rpc       = ($urandom_range(0, 3) == 0) ? (24'hFFFFFE | 24'($urandom_range(0, 1)))
                                                    : 24'($urandom);
            ready     = ($urandom_range(0, 99) < 70);
            mem_delay = $urandom_range(0, 3);
            cycle();
        end
        halt = 1'b0; redirect = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
